// File: rtl/rf_pkg.sv
// Shared defaults and the target-legality helper for the scoreboarded register file.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 32;

  // A register index may be written or marked pending only if it exists and is not the hardwired zero.
  function automatic logic legal_target(input int idx, input int depth, input int zero_reg);
    return (idx >= 32'sd0) && (idx < depth) && !((zero_reg != 32'sd0) && (idx == 32'sd0));
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bundle of the scoreboarded register file.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              pend1;
  logic              pend2;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              pend_any;

  modport master (
    output ra1, ra2, we, wa, wd, iss_valid, iss_rd,
    input  rd1, rd2, pend1, pend2, pend_any
  );

  modport slave (
    input  ra1, ra2, we, wa, wd, iss_valid, iss_rd,
    output rd1, rd2, pend1, pend2, pend_any
  );

endinterface

// File: rtl/rf_scoreboard.sv
// One pending bit per register: set on issue, cleared on writeback, issue wins on collision.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  output logic [DEPTH-1:0]  pend,
  output logic              pend_any
);

  logic [DEPTH-1:0] pend_next;

  // Next pending vector; a new producer overrides a same-cycle writeback.
  always_comb begin
    pend_next = pend;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_valid && (iss_rd == ADDR_W'(i)) && legal_target(i, DEPTH, ZERO_REG)) begin
        pend_next[i] = 1'b1;
      end else if (we && (wa == ADDR_W'(i))) begin
        pend_next[i] = 1'b0;
      end else begin
        pend_next[i] = pend[i];
      end
    end
  end

  // Pending flops; pend_any is registered from the same next-state so it tracks pend exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= {DEPTH{1'b0}};
      pend_any <= 1'b0;
    end else begin
      pend     <= pend_next;
      pend_any <= |pend_next;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with optional bypass, zero register and per-register pending bits.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave rf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              write_ok;
  logic [ADDR_W-1:0] ra  [2];
  logic [DATA_W-1:0] rd  [2];
  logic              pnd [2];

  assign write_ok = rf.we && legal_target(int'(rf.wa), DEPTH, ZERO_REG);
  assign ra[0]    = rf.ra1;
  assign ra[1]    = rf.ra2;
  assign rf.rd1   = rd[0];
  assign rf.rd2   = rd[1];
  assign rf.pend1 = pnd[0];
  assign rf.pend2 = pnd[1];

  // Storage; reset preloads either the index or zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : {DATA_W{1'b0}};
      end
    end else if (write_ok) begin
      mem[rf.wa[IDX_W-1:0]] <= rf.wd;
    end
  end

  // Read ports; a forwarded writeback also resolves the operand hazard in the same cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p]  = {DATA_W{1'b0}};
      pnd[p] = 1'b0;
      if (!legal_target(int'(ra[p]), DEPTH, ZERO_REG)) begin
        rd[p]  = {DATA_W{1'b0}};
        pnd[p] = 1'b0;
      end else if ((BYPASS != 0) && write_ok && (rf.wa == ra[p])) begin
        rd[p]  = rf.wd;
        pnd[p] = 1'b0;
      end else begin
        rd[p]  = mem[ra[p][IDX_W-1:0]];
        pnd[p] = pend[ra[p][IDX_W-1:0]];
      end
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (rf.iss_valid),
    .iss_rd    (rf.iss_rd),
    .we        (rf.we),
    .wa        (rf.wa),
    .pend      (pend),
    .pend_any  (rf.pend_any)
  );

endmodule
